// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W           = 16;
   localparam int unsigned DATA_W           = 16;
   localparam int unsigned STARVE_LIMIT_DEF = 4;
   localparam int unsigned TIMEOUT_DEF      = 15;

   localparam logic [DATA_W-1:0] RDATA_ABORT = DATA_W'(16'hFFFF);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

   // Instruction fetches are always reads with zeroed write data.
   function automatic mem_cmd_t fetch_cmd(input logic [ADDR_W-1:0] addr);
      mem_cmd_t c;
      c.we    = 1'b0;
      c.addr  = addr;
      c.wdata = '0;
      return c;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the memory port arbiter.
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_done;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_done;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   logic              stall_if;
   logic              stall_mem;
   logic              timeout_err;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      output i_done, i_rdata, d_done, d_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output stall_if, stall_mem, timeout_err
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      input  i_done, i_rdata, d_done, d_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  stall_if, stall_mem, timeout_err
   );

endinterface

// File: rtl/arb_timeout_counter.sv
// Counts cycles spent waiting for mem_ack; term_c flags the last allowed cycle.
module arb_timeout_counter #(
   parameter int unsigned LIMIT = 15
) (
   input  logic Clk,
   input  logic Rst,
   input  logic clr,
   output logic term_c
);

   localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)          cnt_q <= '0;
      else if (clr)     cnt_q <= '0;
      else if (!term_c) cnt_q <= cnt_q + CW'(1);
   end

   assign term_c = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory,
// data first with bounded instruction starvation and a memory-timeout abort.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
   input  logic               Clk,
   input  logic               Rst,
   mem_port_arbiter_if.master bus
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_t        state_q, state_d;
   logic [SW-1:0]     starve_q, starve_d;
   mem_cmd_t          cmd_q, cmd_d;
   logic              mem_req_q, mem_req_d;
   logic              i_done_q, i_done_d;
   logic              d_done_q, d_done_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              timeout_q, timeout_d;
   logic              wait_clr_c;
   logic              wait_term_c;

   assign wait_clr_c = (state_q == IDLE) || bus.mem_ack;

   arb_timeout_counter #(.LIMIT(TIMEOUT)) u_wait (
      .Clk    (Clk),
      .Rst    (Rst),
      .clr    (wait_clr_c),
      .term_c (wait_term_c)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= IDLE;
         starve_q  <= '0;
         cmd_q     <= '0;
         mem_req_q <= 1'b0;
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         cmd_q     <= cmd_d;
         mem_req_q <= mem_req_d;
         i_done_q  <= i_done_d;
         d_done_q  <= d_done_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      starve_d  = starve_q;
      cmd_d     = cmd_q;
      mem_req_d = mem_req_q;
      i_done_d  = 1'b0;
      d_done_d  = 1'b0;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      timeout_d = timeout_q;

      case (state_q)
         // Requests are still high while done pulses, so skip arbitration then.
         IDLE: begin
            if (!(i_done_q || d_done_q)) begin
               if (bus.d_req && !(bus.i_req && starve_q == STARVE_MAX)) begin
                  state_d    = SERVE_D;
                  mem_req_d  = 1'b1;
                  cmd_d.we   = bus.d_we;
                  cmd_d.addr = bus.d_addr;
                  cmd_d.wdata = bus.d_wdata;
                  if (bus.i_req) starve_d = starve_q + SW'(1);
               end else if (bus.i_req) begin
                  state_d   = SERVE_I;
                  mem_req_d = 1'b1;
                  cmd_d     = fetch_cmd(bus.i_addr);
                  starve_d  = '0;
               end
            end
         end
         SERVE_I: begin
            if (bus.mem_ack || wait_term_c) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               i_done_d  = 1'b1;
               i_rdata_d = bus.mem_ack ? bus.mem_rdata : RDATA_ABORT;
               timeout_d = timeout_q | ~bus.mem_ack;
            end
         end
         SERVE_D: begin
            if (bus.mem_ack || wait_term_c) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               d_done_d  = 1'b1;
               if (!cmd_q.we) d_rdata_d = bus.mem_ack ? bus.mem_rdata : RDATA_ABORT;
               timeout_d = timeout_q | ~bus.mem_ack;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = cmd_q.we;
   assign bus.mem_addr    = cmd_q.addr;
   assign bus.mem_wdata   = cmd_q.wdata;
   assign bus.i_done      = i_done_q;
   assign bus.d_done      = d_done_q;
   assign bus.i_rdata     = i_rdata_q;
   assign bus.d_rdata     = d_rdata_q;
   assign bus.timeout_err = timeout_q;
   assign bus.stall_if    = bus.i_req & ~i_done_q;
   assign bus.stall_mem   = bus.d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a cycle-level reference model.
module tb_mem_port_arbiter;

   localparam int STARVE = 4;
   localparam int TMO    = 15;

   logic Clk;
   logic Rst;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus.master)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int vectors    = 0;
   int miscompares = 0;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: who owns the port, how long mem_req has been up, starvation count.
   int          m_owner;
   int          m_age;
   int          m_starve;
   logic        m_req, m_we, m_idone, m_ddone, m_err, m_was_done, m_abort;
   logic [15:0] m_addr, m_wdata, m_irdata, m_drdata;

   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         m_owner = 0; m_age = 0; m_starve = 0;
         m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
         m_idone = 0; m_ddone = 0; m_irdata = 0; m_drdata = 0; m_err = 0;
      end else begin
         m_was_done = m_idone | m_ddone;
         m_idone = 0;
         m_ddone = 0;
         if (m_owner == 0) begin
            if (!m_was_done) begin
               if (bus.d_req && !(bus.i_req && m_starve == STARVE)) begin
                  m_owner = 2; m_age = 1; m_req = 1;
                  m_we = bus.d_we; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
                  if (bus.i_req && m_starve < STARVE) m_starve++;
               end else if (bus.i_req) begin
                  m_owner = 1; m_age = 1; m_req = 1;
                  m_we = 0; m_addr = bus.i_addr; m_wdata = 0;
                  m_starve = 0;
               end
            end
         end else if (bus.mem_ack || m_age == TMO) begin
            m_abort = !bus.mem_ack;
            if (m_owner == 1) begin
               m_idone = 1;
               m_irdata = m_abort ? 16'hFFFF : bus.mem_rdata;
            end else begin
               m_ddone = 1;
               if (!m_we) m_drdata = m_abort ? 16'hFFFF : bus.mem_rdata;
            end
            if (m_abort) m_err = 1;
            m_req = 0;
            m_owner = 0;
         end else begin
            m_age++;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge Clk) begin
      #2;
      check("mem_req",     16'(bus.mem_req),     16'(m_req));
      check("mem_we",      16'(bus.mem_we),      16'(m_we));
      check("mem_addr",    bus.mem_addr,         m_addr);
      check("mem_wdata",   bus.mem_wdata,        m_wdata);
      check("i_done",      16'(bus.i_done),      16'(m_idone));
      check("d_done",      16'(bus.d_done),      16'(m_ddone));
      check("i_rdata",     bus.i_rdata,          m_irdata);
      check("d_rdata",     bus.d_rdata,          m_drdata);
      check("timeout_err", 16'(bus.timeout_err), 16'(m_err));
      check("stall_if",    16'(bus.stall_if),    16'(bus.i_req & ~m_idone));
      check("stall_mem",   16'(bus.stall_mem),   16'(bus.d_req & ~m_ddone));
   end

   // Memory responder: ack after a chosen latency, returns backing-store data.
   logic [15:0] gmem [256];
   int          hi_cnt, cur_lat, ack_lat;
   bit          rand_mode, force_en;
   logic [15:0] force_val;

   always @(negedge Clk) begin
      if (Rst) begin
         hi_cnt = 0;
         bus.mem_ack = 1'b0;
         bus.mem_rdata = 16'h0;
         for (int k = 0; k < 256; k++) gmem[k] = 16'(k * 16'h0101) ^ 16'h5A00;
      end else if (bus.mem_req) begin
         hi_cnt++;
         if (hi_cnt == 1)
            cur_lat = !rand_mode ? ack_lat :
                      ($urandom_range(0, 11) == 0) ? 40 : int'($urandom_range(0, 4));
         if (hi_cnt == cur_lat + 1) begin
            bus.mem_ack = 1'b1;
            if (bus.mem_we) gmem[bus.mem_addr[7:0]] = bus.mem_wdata;
            bus.mem_rdata = force_en ? force_val : gmem[bus.mem_addr[7:0]];
         end else begin
            bus.mem_ack = 1'b0;
            bus.mem_rdata = 16'($urandom);
         end
      end else begin
         hi_cnt = 0;
         bus.mem_ack = rand_mode && ($urandom_range(0, 9) == 0);
         bus.mem_rdata = 16'($urandom);
      end
   end

   // Grant log: address at every mem_req rising edge.
   logic [15:0] grants [$];
   logic        g_prev = 1'b0;

   always @(negedge Clk) begin
      #1;
      if (bus.mem_req && !g_prev) grants.push_back(bus.mem_addr);
      g_prev = bus.mem_req;
   end

   task automatic at_cycle(input int n);
      repeat (n) @(negedge Clk);
      #3;
   endtask

   task automatic idle_bus();
      bus.i_req = 0; bus.i_addr = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
   endtask

   initial begin
      Rst = 1'b1;
      idle_bus();
      rand_mode = 0; force_en = 0; force_val = 0; ack_lat = 0;

      at_cycle(2);
      check("rst_mem_req", 16'(bus.mem_req), 16'h0);
      check("rst_i_done",  16'(bus.i_done),  16'h0);
      check("rst_err",     16'(bus.timeout_err), 16'h0);
      check("rst_addr",    bus.mem_addr, 16'h0);
      @(negedge Clk);
      Rst = 1'b0;

      // Single fetch, ack one cycle after mem_req.
      @(negedge Clk);
      bus.i_req = 1; bus.i_addr = 16'h0010; ack_lat = 1; force_en = 1; force_val = 16'hA5A5;
      at_cycle(1);
      check("t38_mreq_c1", 16'(bus.mem_req), 16'h1);
      check("t38_we_c1",   16'(bus.mem_we),  16'h0);
      check("t38_addr_c1", bus.mem_addr, 16'h0010);
      at_cycle(2);
      check("t38_done_c3",  16'(bus.i_done), 16'h1);
      check("t38_rdata_c3", bus.i_rdata, 16'hA5A5);
      check("t38_model_done", 16'(m_idone), 16'h1);
      check("t38_model_rdata", m_irdata, 16'hA5A5);
      bus.i_req = 0;
      force_en = 0;
      at_cycle(2);

      // Simultaneous store and fetch: data first, one idle bubble, then fetch.
      bus.i_req = 1; bus.i_addr = 16'h0100;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0040; bus.d_wdata = 16'h1234;
      ack_lat = 0;
      at_cycle(1);
      check("t39_we_c1",    16'(bus.mem_we), 16'h1);
      check("t39_addr_c1",  bus.mem_addr, 16'h0040);
      check("t39_wdata_c1", bus.mem_wdata, 16'h1234);
      check("t39_stall_c1", 16'(bus.stall_if), 16'h1);
      at_cycle(1);
      check("t39_ddone_c2", 16'(bus.d_done), 16'h1);
      check("t39_stall_c2", 16'(bus.stall_if), 16'h1);
      idle_bus();
      bus.i_req = 1; bus.i_addr = 16'h0100;
      at_cycle(1);
      check("t39_bubble_c3", 16'(bus.mem_req), 16'h0);
      check("t39_stall_c3",  16'(bus.stall_if), 16'h1);
      at_cycle(1);
      check("t39_imreq_c4", 16'(bus.mem_req), 16'h1);
      check("t39_iwe_c4",   16'(bus.mem_we), 16'h0);
      check("t39_iaddr_c4", bus.mem_addr, 16'h0100);
      check("t39_stall_c4", 16'(bus.stall_if), 16'h1);
      at_cycle(1);
      check("t39_idone_c5", 16'(bus.i_done), 16'h1);
      idle_bus();
      at_cycle(3);

      // Starvation bound: both requests held continuously.
      grants.delete();
      bus.i_req = 1; bus.i_addr = 16'h1000;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h2000;
      for (int k = 0; k < 200 && grants.size() < 10; k++) @(negedge Clk);
      #3;
      check("t40_ngrants", 16'(grants.size()), 16'd10);
      for (int k = 0; k < 10 && k < grants.size(); k++)
         check($sformatf("t40_grant%0d", k), grants[k], (k == 4 || k == 9) ? 16'h1000 : 16'h2000);
      check("t40_model_starve", 16'(m_starve), 16'h0);
      idle_bus();
      at_cycle(5);

      // Memory never acks: abort after TMO cycles of mem_req.
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0080; ack_lat = 99;
      for (int k = 1; k <= TMO; k++) begin
         at_cycle(1);
         check($sformatf("t41_mreq_c%0d", k), 16'(bus.mem_req), 16'h1);
      end
      at_cycle(1);
      check("t41_mreq_drop", 16'(bus.mem_req), 16'h0);
      check("t41_ddone",     16'(bus.d_done), 16'h1);
      check("t41_rdata",     bus.d_rdata, 16'hFFFF);
      check("t41_err",       16'(bus.timeout_err), 16'h1);
      idle_bus();
      at_cycle(4);
      check("t41_err_sticky", 16'(bus.timeout_err), 16'h1);

      // Asynchronous reset while serving a data load.
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0090;
      repeat (2) @(negedge Clk);
      @(posedge Clk);
      #3;
      check("t42_serving", 16'(bus.mem_req), 16'h1);
      Rst = 1'b1;
      #1;
      check("t42_mreq_async", 16'(bus.mem_req), 16'h0);
      check("t42_err_clr",    16'(bus.timeout_err), 16'h0);
      idle_bus();
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      at_cycle(1);
      check("t42_no_done_a", 16'(bus.d_done), 16'h0);
      bus.i_req = 1; bus.i_addr = 16'h0020; ack_lat = 1; force_en = 1; force_val = 16'h3C3C;
      at_cycle(1);
      check("t42_regrant_c1", 16'(bus.mem_req), 16'h1);
      check("t42_no_done_b",  16'(bus.d_done), 16'h0);
      at_cycle(2);
      check("t42_idone_c3", 16'(bus.i_done), 16'h1);
      check("t42_rdata_c3", bus.i_rdata, 16'h3C3C);
      idle_bus();
      force_en = 0;
      at_cycle(2);

      // Randomized traffic, random ack latency, spurious idle acks, early drops.
      rand_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge Clk);
         if (bus.i_req) begin
            if (bus.i_done) begin
               if ($urandom_range(0, 1) == 0) bus.i_req = 0;
               else bus.i_addr = 16'($urandom);
            end else if ($urandom_range(0, 49) == 0) bus.i_req = 0;
         end else if ($urandom_range(0, 3) == 0) begin
            bus.i_req = 1; bus.i_addr = 16'($urandom);
         end
         if (bus.d_req) begin
            if (bus.d_done) begin
               if ($urandom_range(0, 1) == 0) bus.d_req = 0;
               else begin
                  bus.d_we = 1'($urandom); bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
               end
            end else if ($urandom_range(0, 49) == 0) bus.d_req = 0;
         end else if ($urandom_range(0, 2) == 0) begin
            bus.d_req = 1; bus.d_we = 1'($urandom);
            bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
         end
      end
      @(negedge Clk);
      idle_bus();
      rand_mode = 0;
      repeat (60) @(negedge Clk);
      #4;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants made while an instruction request waits.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles mem_req may stay high without mem_ack.
REQ-003 Clk  in  1  single clock, all state on rising edge.
REQ-004 Rst  in  1  reset, asynchronous, active-high.
REQ-005 i_req  in  1  instruction-fetch read request, held until i_done.
REQ-006 i_addr  in  16  instruction address, stable while i_req.
REQ-007 i_done  out  1  one-cycle pulse: instruction read complete.
REQ-008 i_rdata  out  16  instruction word, valid from i_done and held until the next I completion.
REQ-009 d_req  in  1  data-access request, held until d_done.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  16  data address.
REQ-012 d_wdata  in  16  store data.
REQ-013 d_done  out  1  one-cycle pulse: data access complete.
REQ-014 d_rdata  out  16  load data, valid from d_done and held until the next D load completion.
REQ-015 mem_req  out  1  shared single-port memory request, registered.
REQ-016 mem_we  out  1  write enable to memory, registered.
REQ-017 mem_addr  out  16  address to memory, registered.
REQ-018 mem_wdata  out  16  write data to memory, registered.
REQ-019 mem_rdata  in  16  memory read data, valid with mem_ack.
REQ-020 mem_ack  in  1  memory completion, one cycle.
REQ-021 stall_if  out  1  fetch stage must hold PC and instruction.
REQ-022 stall_mem  out  1  MEM stage and all earlier stages must hold.
REQ-023 timeout_err  out  1  sticky memory-timeout flag.

Function
REQ-024 The FSM SHALL have exactly three states: IDLE, SERVE_I, SERVE_D.
REQ-025 In IDLE with any request pending, the arbiter SHALL choose a winner, latch its addr/we/wdata into mem_* and assert mem_req on the next cycle. I transactions drive mem_we=0 and mem_wdata=0.
REQ-026 Priority: D wins over I unless starve_cnt==STARVE_LIMIT with i_req high, in which case I wins.
REQ-027 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each D grant while i_req=1; it SHALL clear on each I grant.
REQ-028 In SERVE_x, mem_* outputs SHALL stay stable until mem_ack; on mem_ack the arbiter SHALL drop mem_req, pulse x_done, capture mem_rdata into x_rdata on reads only, and return to IDLE.
REQ-029 Minimum latency: req at cycle 0 -> mem_req at cycle 1 -> with ack at cycle 1, done at cycle 2; one IDLE bubble between back-to-back transactions.
REQ-030 mem_ack received in IDLE SHALL be ignored.
REQ-031 wait_cnt SHALL count cycles in SERVE_x without mem_ack; on reaching TIMEOUT, the arbiter SHALL abort: drop mem_req, pulse x_done, set x_rdata=16'hFFFF on reads, set timeout_err, and go to IDLE.
REQ-032 A requester deasserting its request mid-transaction SHALL not abort it; done still pulses.
REQ-033 Stall outputs, combinational: stall_if = i_req & ~i_done; stall_mem = d_req & ~d_done.

Reset
REQ-034 Rst SHALL force IDLE, clear starve_cnt, wait_cnt, mem_req, mem_we, mem_addr, mem_wdata, i_done, d_done, i_rdata, d_rdata and timeout_err to 0, and abandon any in-flight transaction.
REQ-035 After Rst deasserts, the first grant SHALL follow REQ-025 with no extra delay.

Structure
REQ-036 The state encoding and the default STARVE_LIMIT/TIMEOUT values SHALL live in the shared CPU package.
REQ-037 A single sub-module, arb_timeout_counter (a wait counter with clear and terminal flag), is permitted; everything else stays flat.

Verification
REQ-038 Single I read, ack 1 cycle after mem_req, rdata 16'hA5A5 -> i_done at cycle 3 with i_rdata=16'hA5A5 and mem_we=0.
REQ-039 Simultaneous i_req and d_req (store 16'h1234 to 16'h0040) -> D served first with mem_we=1; I served next; stall_if high throughout.
REQ-040 i_req held and d_req re-asserted continuously, STARVE_LIMIT=4 -> exactly 4 D grants, then an I grant, then starve_cnt=0.
REQ-041 mem_ack never arrives, TIMEOUT=15 -> abort 15 cycles after mem_req rises, d_done pulse, d_rdata=16'hFFFF, timeout_err stays 1 until Rst.
REQ-042 Rst asserted asynchronously in SERVE_D -> mem_req=0 immediately, no done pulse, and the next request is granted normally.
